mem_stage: RTL and testbench

- Pipeline stage that consumes the EX-stage result bundle: write-enable, destination register, ALU result and memory-op fields.
- Non-memory results are registered straight through to write-back.
- Load/store ops run a multi-cycle req/ack data-bus transaction; `stallreq_o` freezes the upstream pipeline until the access completes.
- Combines the EX/MEM latch, MEM logic and MEM/WB register into one sequential block.

---
 rtl/mem_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory pipeline stage. Takes the EX result bundle and either
//             passes it straight to write-back, or runs a req/ack data-bus
//             transaction for LB/LBU/LW/SB/SW. The upstream pipeline is
//             frozen through stallreq_o until the access is acknowledged.
//             The EX/MEM latch, the MEM logic and the MEM/WB register are all
//             folded into one sequential block.
//  Ports    : clk, rst (async, active-low)
//             ex_*        : EX-stage result bundle (op, wreg, wd, wdata, store data)
//             mem_*       : data-bus request/response
//             stallreq_o  : freeze PC/IF/ID/EX
//             misalign_o  : one-cycle pulse when a misaligned LW/SW is dropped
//             wb_*        : registered write-back bundle
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // register/data width, fixed at 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ex_aluop_i,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              stallreq_o,
  output logic              misalign_o,
  output logic              wb_wreg_o,
  output logic [4:0]        wb_wd_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  localparam logic [7:0] C_EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] C_EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] C_EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] C_EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] C_EXE_SW_OP  = 8'hEB;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Registered state
  state_t              r_state;
  logic [7:0]          r_op;      // held op, selects load extension
  logic [1:0]          r_lane;    // held addr[1:0], selects load byte
  logic                r_wreg;
  logic [4:0]          r_wd;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_sel;
  logic [DATA_W-1:0]   r_data;
  logic                r_misalign;
  logic                r_wb_wreg;
  logic [4:0]          r_wb_wd;
  logic [DATA_W-1:0]   r_wb_wdata;

  // Next-state values
  state_t              w_state_nxt;
  logic [7:0]          w_op_nxt;
  logic [1:0]          w_lane_nxt;
  logic                w_wreg_nxt;
  logic [4:0]          w_wd_nxt;
  logic                w_req_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [3:0]          w_sel_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_misalign_nxt;
  logic                w_wb_wreg_nxt;
  logic [4:0]          w_wb_wd_nxt;
  logic [DATA_W-1:0]   w_wb_wdata_nxt;
  logic                w_stall;

  // Decode of the op currently presented by EX
  logic w_is_lb, w_is_lbu, w_is_lw, w_is_sb, w_is_sw;
  logic w_is_mem, w_is_word, w_is_store, w_misaligned, w_start;
  logic [3:0]        w_sel_new;
  logic [DATA_W-1:0] w_data_new;

  assign w_is_lb      = (ex_aluop_i == C_EXE_LB_OP);
  assign w_is_lbu     = (ex_aluop_i == C_EXE_LBU_OP);
  assign w_is_lw      = (ex_aluop_i == C_EXE_LW_OP);
  assign w_is_sb      = (ex_aluop_i == C_EXE_SB_OP);
  assign w_is_sw      = (ex_aluop_i == C_EXE_SW_OP);
  assign w_is_mem     = w_is_lb | w_is_lbu | w_is_lw | w_is_sb | w_is_sw;
  assign w_is_word    = w_is_lw | w_is_sw;
  assign w_is_store   = w_is_sb | w_is_sw;
  // Byte ops can never be misaligned; only word ops check the low bits.
  assign w_misaligned = w_is_word && (ex_wdata_i[1:0] != 2'b00);
  assign w_start      = w_is_mem && !w_misaligned;

  // Big-endian lanes: byte address 0 lives in bits 31:24 (sel bit 3).
  assign w_sel_new  = w_is_word ? 4'b1111 : (4'b1000 >> ex_wdata_i[1:0]);
  assign w_data_new = w_is_sb ? {4{ex_store_data_i[7:0]}} :
                      w_is_sw ? ex_store_data_i : '0;

  // Load-data extraction for the held access
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_load_data;

  always_comb begin
    w_byte = mem_data_i[31:24];
    case (r_lane)
      2'b00:   w_byte = mem_data_i[31:24];
      2'b01:   w_byte = mem_data_i[23:16];
      2'b10:   w_byte = mem_data_i[15:8];
      default: w_byte = mem_data_i[7:0];
    endcase
  end

  assign w_load_data = (r_op == C_EXE_LW_OP) ? mem_data_i :
                       (r_op == C_EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte} :
                                               {24'd0, w_byte};

  // Next-state / output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_lane_nxt     = r_lane;
    w_wreg_nxt     = r_wreg;
    w_wd_nxt       = r_wd;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_sel_nxt      = r_sel;
    w_data_nxt     = r_data;
    w_misalign_nxt = 1'b0;
    w_wb_wreg_nxt  = r_wb_wreg;
    w_wb_wd_nxt    = r_wb_wd;
    w_wb_wdata_nxt = r_wb_wdata;
    w_stall        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stall       = 1'b1;
          w_state_nxt   = ACCESS;
          w_op_nxt      = ex_aluop_i;
          w_lane_nxt    = ex_wdata_i[1:0];
          w_wreg_nxt    = ex_wreg_i;
          w_wd_nxt      = ex_wd_i;
          w_req_nxt     = 1'b1;
          w_we_nxt      = w_is_store;
          w_addr_nxt    = {ex_wdata_i[ADDR_W-1:2], 2'b00};
          w_sel_nxt     = w_sel_new;
          w_data_nxt    = w_data_new;
          w_wb_wreg_nxt = 1'b0;              // bubble while the access runs
        end else if (w_misaligned) begin
          w_wb_wreg_nxt  = 1'b0;
          w_misalign_nxt = 1'b1;
        end else begin
          w_wb_wreg_nxt  = ex_wreg_i;
          w_wb_wd_nxt    = ex_wd_i;
          w_wb_wdata_nxt = ex_wdata_i;
        end
      end
      ACCESS: begin
        // Release upstream in the ack cycle so the next op arrives right
        // after the return to IDLE; the op seen during ack is the held one.
        w_stall = ~mem_ack_i;
        if (mem_ack_i) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = '0;
          w_sel_nxt   = 4'b0000;
          w_data_nxt  = '0;
          if (r_we) begin
            w_wb_wreg_nxt = 1'b0;
          end else begin
            w_wb_wreg_nxt  = r_wreg;
            w_wb_wd_nxt    = r_wd;
            w_wb_wdata_nxt = w_load_data;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_lane     <= '0;
      r_wreg     <= 1'b0;
      r_wd       <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      r_wb_wreg  <= 1'b0;
      r_wb_wd    <= '0;
      r_wb_wdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_lane     <= w_lane_nxt;
      r_wreg     <= w_wreg_nxt;
      r_wd       <= w_wd_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_sel      <= w_sel_nxt;
      r_data     <= w_data_nxt;
      r_misalign <= w_misalign_nxt;
      r_wb_wreg  <= w_wb_wreg_nxt;
      r_wb_wd    <= w_wb_wd_nxt;
      r_wb_wdata <= w_wb_wdata_nxt;
    end
  end

  // Stall is masked while reset is asserted so an aborted access releases
  // the pipeline immediately, even if EX still shows a memory op.
  assign stallreq_o = rst & w_stall;
  assign mem_req_o  = r_req;
  assign mem_we_o   = r_we;
  assign mem_addr_o = r_addr;
  assign mem_sel_o  = r_sel;
  assign mem_data_o = r_data;
  assign misalign_o = r_misalign;
  assign wb_wreg_o  = r_wb_wreg;
  assign wb_wd_o    = r_wb_wd;
  assign wb_wdata_o = r_wb_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed scenarios plus a
//             randomized back-to-back sequence checked against a behavioural
//             model of the memory-stage rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_OR  = 8'h25;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ex_aluop_i = '0;
  logic        ex_wreg_i = 1'b0;
  logic [4:0]  ex_wd_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic [31:0] ex_store_data_i = '0;
  logic        mem_req_o, mem_we_o, stallreq_o, misalign_o, wb_wreg_o;
  logic [31:0] mem_addr_o, mem_data_o, wb_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [4:0]  wb_wd_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_aluop_i(ex_aluop_i), .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
    .ex_wdata_i(ex_wdata_i), .ex_store_data_i(ex_store_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .wb_wreg_o(wb_wreg_o), .wb_wd_o(wb_wd_o), .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic bit m_is_mem(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW};
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return op inside {OP_SB, OP_SW};
  endfunction

  function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] a);
    return (op inside {OP_LW, OP_SW}) && (a % 4 != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    if (op inside {OP_LW, OP_SW}) return 4'hF;
    return 4'(8 / (1 << (a % 4)));     // lane 0 -> 8, 1 -> 4, 2 -> 2, 3 -> 1
  endfunction

  function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] d);
    if (op == OP_SW) return d;
    return (d % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] d);
    int unsigned b;
    int v;
    if (op == OP_LW) return d;
    b = (d / (32'd1 << (8 * (3 - (a % 4))))) % 256;   // big-endian byte
    v = int'(b);
    if (op == OP_LB && b >= 128) v = v - 256;
    return 32'(v);
  endfunction

  function automatic logic [7:0] rand_nonmem_op();
    logic [7:0] op;
    do op = 8'($urandom); while (m_is_mem(op));
    return op;
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    #12;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
    n_checks++; if ({wb_wreg_o, wb_wd_o, wb_wdata_o, misalign_o, mem_sel_o, mem_addr_o} !== '0) begin
      n_fail++; $display("FAIL reset_outs got wreg=%b wd=%h wdata=%h mis=%b sel=%h addr=%h exp all 0",
                         wb_wreg_o, wb_wd_o, wb_wdata_o, misalign_o, mem_sel_o, mem_addr_o); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem(input logic [7:0] op, input logic wreg, input logic [4:0] wd,
                             input logic [31:0] wdata);
    ex_aluop_i = op; ex_wreg_i = wreg; ex_wd_i = wd; ex_wdata_i = wdata;
    ex_store_data_i = $urandom;
    #1;
    n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall op=%h got=%b exp=0", op, stallreq_o); end
    @(posedge clk); #1;
    n_checks++; if ({wb_wreg_o, wb_wd_o, wb_wdata_o} !== {wreg, wd, wdata}) begin
      n_fail++; $display("FAIL nonmem_wb op=%h got=%b/%h/%h exp=%b/%h/%h",
                         op, wb_wreg_o, wb_wd_o, wb_wdata_o, wreg, wd, wdata); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL nonmem_req got=%b exp=0", mem_req_o); end
  endtask

  task automatic test_mem_access(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] ldata,
                                 input int waits, input logic wreg, input logic [4:0] wd);
    logic [31:0] exp_addr;
    exp_addr = addr - (addr % 4);
    ex_aluop_i = op; ex_wreg_i = wreg; ex_wd_i = wd; ex_wdata_i = addr; ex_store_data_i = sdata;
    #1;
    n_checks++; if (stallreq_o !== 1'b1) begin n_fail++; $display("FAIL mem_start_stall op=%h got=%b exp=1", op, stallreq_o); end
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin mem_ack_i = 1'b1; mem_data_i = ldata; end
      else mem_data_i = $urandom;
      #1;
      n_checks++; if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o} !== {1'b1, m_is_store(op), m_sel(op, addr), exp_addr}) begin
        n_fail++; $display("FAIL mem_bus op=%h cyc=%0d got req=%b we=%b sel=%h addr=%h exp 1/%b/%h/%h", op, i,
                           mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, m_is_store(op), m_sel(op, addr), exp_addr); end
      if (m_is_store(op)) begin
        n_checks++; if (mem_data_o !== m_store(op, sdata)) begin
          n_fail++; $display("FAIL mem_sdata op=%h got=%h exp=%h", op, mem_data_o, m_store(op, sdata)); end
      end
      n_checks++; if (stallreq_o !== (i != waits)) begin
        n_fail++; $display("FAIL mem_stall op=%h cyc=%0d got=%b exp=%b", op, i, stallreq_o, i != waits); end
      n_checks++; if (wb_wreg_o !== 1'b0) begin n_fail++; $display("FAIL mem_bubble cyc=%0d got=%b exp=0", i, wb_wreg_o); end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL mem_req_drop got=%b exp=0", mem_req_o); end
    if (m_is_store(op)) begin
      n_checks++; if (wb_wreg_o !== 1'b0) begin n_fail++; $display("FAIL store_wb got=%b exp=0", wb_wreg_o); end
    end else begin
      n_checks++; if ({wb_wreg_o, wb_wd_o, wb_wdata_o} !== {wreg, wd, m_load(op, addr, ldata)}) begin
        n_fail++; $display("FAIL load_wb op=%h got=%b/%h/%h exp=%b/%h/%h", op, wb_wreg_o, wb_wd_o,
                           wb_wdata_o, wreg, wd, m_load(op, addr, ldata)); end
    end
  endtask

  task automatic test_misaligned(input logic [7:0] op, input logic [31:0] addr);
    logic [31:0] d;
    ex_aluop_i = op; ex_wreg_i = 1'b1; ex_wd_i = 5'd9; ex_wdata_i = addr; ex_store_data_i = $urandom;
    #1;
    n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL mis_stall got=%b exp=0", stallreq_o); end
    @(posedge clk); #1;
    n_checks++; if ({misalign_o, wb_wreg_o, mem_req_o} !== 3'b100) begin
      n_fail++; $display("FAIL mis_pulse got mis=%b wreg=%b req=%b exp 1/0/0", misalign_o, wb_wreg_o, mem_req_o); end
    d = $urandom;
    ex_aluop_i = OP_OR; ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = d;
    @(posedge clk); #1;
    n_checks++; if ({misalign_o, wb_wreg_o, wb_wdata_o} !== {2'b01, d}) begin
      n_fail++; $display("FAIL mis_after got mis=%b wreg=%b wdata=%h exp 0/1/%h", misalign_o, wb_wreg_o, wb_wdata_o, d); end
  endtask

  task automatic test_ack_in_idle();
    mem_ack_i = 1'b1;
    test_nonmem(OP_OR, 1'b1, 5'd12, 32'h1357_9BDF);
    mem_ack_i = 1'b0;
  endtask

  task automatic test_async_reset();
    ex_aluop_i = OP_LW; ex_wreg_i = 1'b1; ex_wd_i = 5'd6; ex_wdata_i = 32'h0000_4000;
    @(posedge clk); #1;
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL ares_pre_req got=%b exp=1", mem_req_o); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_req_o, stallreq_o, wb_wreg_o, wb_wd_o, wb_wdata_o} !== '0) begin
      n_fail++; $display("FAIL ares_clear got req=%b stall=%b wreg=%b wd=%h wdata=%h exp all 0",
                         mem_req_o, stallreq_o, wb_wreg_o, wb_wd_o, wb_wdata_o); end
    ex_aluop_i = OP_OR; ex_wreg_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    mem_ack_i = 1'b1; mem_data_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    n_checks++; if ({mem_req_o, wb_wreg_o} !== 2'b00) begin
      n_fail++; $display("FAIL ares_late_ack got req=%b wreg=%b exp 0/0", mem_req_o, wb_wreg_o); end
    test_nonmem(OP_OR, 1'b1, 5'd17, 32'hA0A0_0505);   // IDLE: one-cycle pass-through
  endtask

  task automatic test_random_back_to_back();
    logic [7:0] ops [5];
    logic [7:0] op;
    logic [31:0] a;
    ops = '{OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW};
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 5));
      a = $urandom;
      if (k == 5) begin
        test_nonmem(rand_nonmem_op(), 1'($urandom), 5'($urandom), a);
      end else begin
        op = ops[k];
        if (m_misaligned(op, a)) test_misaligned(op, a);
        else test_mem_access(op, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                             1'($urandom), 5'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem(OP_OR, 1'b1, 5'd3, 32'h0000_00FF);
    test_mem_access(OP_LW,  32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 5'd7);
    test_mem_access(OP_LB,  32'h0000_2001, 32'h0, 32'h12F4_5678, 1, 1'b1, 5'd8);
    test_mem_access(OP_LBU, 32'h0000_2001, 32'h0, 32'h12F4_5678, 0, 1'b1, 5'd9);
    test_mem_access(OP_SB,  32'h0000_0003, 32'h0000_00A5, 32'h0, 2, 1'b1, 5'd10);
    test_mem_access(OP_SW,  32'h0000_0010, 32'h8765_4321, 32'h0, 1, 1'b0, 5'd0);
    test_misaligned(OP_SW, 32'h0000_0002);
    test_misaligned(OP_LW, 32'h0000_0101);
    test_ack_in_idle();
    test_async_reset();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
